// File: rtl/binary_to_gray_code.sv
// Registered binary-to-Gray encoder with a decode round-trip check and an adjacency monitor.
// Each accepted binary word appears as Gray code one clock later.
module binary_to_gray_code #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] binary,
  output logic [WIDTH-1:0] gray,
  output logic             out_valid,
  output logic [WIDTH-1:0] binary_back,
  output logic             roundtrip_err,
  output logic             single_step,
  output logic [WIDTH:0]   step_count
);

  logic [WIDTH-1:0] gray_next;
  logic [WIDTH-1:0] decode_next;
  logic [WIDTH-1:0] prev_gray;
  logic [WIDTH-1:0] diff;
  logic             have_prev;
  logic             one_bit_diff;

  always_comb begin
    gray_next = binary ^ (binary >> 1);
  end

  // Decode ripples from the MSB down: each binary bit is the XOR of all Gray bits above and at it.
  always_comb begin
    decode_next = '0;
    decode_next[WIDTH-1] = gray_next[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      decode_next[i] = decode_next[i+1] ^ gray_next[i];
    end
  end

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  always_comb begin
    diff         = gray_next ^ prev_gray;
    one_bit_diff = (diff != '0) && ((diff & (diff - WIDTH'(1))) == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gray          <= '0;
      binary_back   <= '0;
      out_valid     <= 1'b0;
      single_step   <= 1'b0;
      roundtrip_err <= 1'b0;
      step_count    <= '0;
      prev_gray     <= '0;
      have_prev     <= 1'b0;
    end else if (in_valid) begin
      gray        <= gray_next;
      binary_back <= decode_next;
      out_valid   <= 1'b1;
      single_step <= have_prev && one_bit_diff;
      prev_gray   <= gray_next;
      have_prev   <= 1'b1;
      if (decode_next != binary) begin
        roundtrip_err <= 1'b1;
      end
      if (step_count != '1) begin
        step_count <= step_count + (WIDTH+1)'(1);
      end
    end else begin
      out_valid   <= 1'b0;
      single_step <= 1'b0;
    end
  end

endmodule

// File: tb/tb_binary_to_gray_code.sv
// Directed bench for binary_to_gray_code: literal checkpoints plus a per-cycle
// comparison against a history-based model of accepted inputs.
module tb_binary_to_gray_code;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic [WIDTH-1:0] binary;
  logic [WIDTH-1:0] gray;
  logic             out_valid;
  logic [WIDTH-1:0] binary_back;
  logic             roundtrip_err;
  logic             single_step;
  logic [WIDTH:0]   step_count;

  int tests_run = 0;
  int tests_failed = 0;
  bit check_en = 1'b0;

  binary_to_gray_code #(.WIDTH(WIDTH)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .binary(binary),
    .gray(gray),
    .out_valid(out_valid),
    .binary_back(binary_back),
    .roundtrip_err(roundtrip_err),
    .single_step(single_step),
    .step_count(step_count)
  );

  always #5 clk = ~clk;

  // Model state: the list of accepted words since reset and the last-cycle view of outputs.
  logic [WIDTH-1:0] accepted[$];
  logic             m_valid = 1'b0;
  logic             m_single = 1'b0;
  logic [WIDTH-1:0] m_gray = '0;
  logic [WIDTH-1:0] m_back = '0;

  function automatic logic [WIDTH-1:0] gray_of(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      accepted.delete();
      m_valid  = 1'b0;
      m_single = 1'b0;
      m_gray   = '0;
      m_back   = '0;
    end else if (in_valid) begin
      m_single = (accepted.size() > 0) &&
                 ($countones(gray_of(accepted[$]) ^ gray_of(binary)) == 1);
      accepted.push_back(binary);
      m_valid = 1'b1;
      m_gray  = gray_of(binary);
      m_back  = binary;
    end else begin
      m_valid  = 1'b0;
      m_single = 1'b0;
    end
  end

  function automatic logic [WIDTH:0] model_count();
    int n;
    n = accepted.size();
    if (n > (2 ** (WIDTH + 1)) - 1) n = (2 ** (WIDTH + 1)) - 1;
    return (WIDTH+1)'(n);
  endfunction

  always @(posedge clk) begin
    #1;
    if (check_en) begin
      tests_run++;
      if ({out_valid, gray, binary_back, single_step, roundtrip_err, step_count} !==
          {m_valid, m_gray, m_back, m_single, 1'b0, model_count()}) begin
        tests_failed++;
        $display("[TB] FAIL model_cycle t=%0t: got v=%b g=%b bb=%b ss=%b err=%b cnt=%0d, expected v=%b g=%b bb=%b ss=%b err=0 cnt=%0d",
                 $time, out_valid, gray, binary_back, single_step, roundtrip_err, step_count,
                 m_valid, m_gray, m_back, m_single, model_count());
      end
    end
  end

  task automatic applyStimulus(input logic valid, input logic [WIDTH-1:0] value);
    @(negedge clk);
    in_valid = valid;
    binary   = value;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic exp_valid,
                             input logic [WIDTH-1:0] exp_gray, input logic [WIDTH-1:0] exp_back,
                             input logic exp_single, input logic [WIDTH:0] exp_count);
    tests_run++;
    if ({out_valid, gray, binary_back, single_step, roundtrip_err, step_count} !==
        {exp_valid, exp_gray, exp_back, exp_single, 1'b0, exp_count}) begin
      tests_failed++;
      $display("[TB] FAIL %s: got v=%b g=%b bb=%b ss=%b err=%b cnt=%0d, expected v=%b g=%b bb=%b ss=%b err=0 cnt=%0d",
               name, out_valid, gray, binary_back, single_step, roundtrip_err, step_count,
               exp_valid, exp_gray, exp_back, exp_single, exp_count);
    end
  endtask

  logic [WIDTH-1:0] sweep_gray [16] = '{
    4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
    4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000
  };

  initial begin
    reset    = 1'b1;
    in_valid = 1'b1;
    binary   = 4'hF;
    #1;
    checkOutput("reset_immediate", 1'b0, 4'b0000, 4'h0, 1'b0, 5'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("reset_held", 1'b0, 4'b0000, 4'h0, 1'b0, 5'd0);
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b0;
    check_en = 1'b1;

    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, WIDTH'(i));
      checkOutput($sformatf("sweep_%0d", i), 1'b1, sweep_gray[i], WIDTH'(i),
                  (i != 0), 5'(i + 1));
    end

    applyStimulus(1'b1, 4'd0);
    checkOutput("wrap_15_to_0", 1'b1, 4'b0000, 4'd0, 1'b1, 5'd17);
    applyStimulus(1'b1, 4'd3);
    checkOutput("pair_3", 1'b1, 4'b0010, 4'd3, 1'b1, 5'd18);
    applyStimulus(1'b1, 4'd12);
    checkOutput("pair_3_12", 1'b1, 4'b1010, 4'd12, 1'b1, 5'd19);
    applyStimulus(1'b1, 4'd5);
    checkOutput("pair_5", 1'b1, 4'b0111, 4'd5, 1'b0, 5'd20);
    applyStimulus(1'b1, 4'd10);
    checkOutput("pair_5_10", 1'b1, 4'b1111, 4'd10, 1'b1, 5'd21);
    applyStimulus(1'b1, 4'd0);
    checkOutput("pair_0", 1'b1, 4'b0000, 4'd0, 1'b0, 5'd22);
    applyStimulus(1'b1, 4'd2);
    checkOutput("pair_0_2", 1'b1, 4'b0011, 4'd2, 1'b0, 5'd23);
    applyStimulus(1'b1, 4'd7);
    checkOutput("repeat_7_first", 1'b1, 4'b0100, 4'd7, 1'b0, 5'd24);
    applyStimulus(1'b1, 4'd7);
    checkOutput("repeat_7_second", 1'b1, 4'b0100, 4'd7, 1'b0, 5'd25);

    applyStimulus(1'b1, 4'd4);
    checkOutput("gap_first", 1'b1, 4'b0110, 4'd4, 1'b1, 5'd26);
    applyStimulus(1'b0, WIDTH'($urandom_range(0, 15)));
    checkOutput("gap_hold", 1'b0, 4'b0110, 4'd4, 1'b0, 5'd26);
    applyStimulus(1'b1, 4'd5);
    checkOutput("gap_after", 1'b1, 4'b0111, 4'd5, 1'b1, 5'd27);

    // Push past 31 accepted words so the counter must saturate.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, WIDTH'(i));
    end
    checkOutput("count_saturated", 1'b1, 4'b0100, 4'd7, 1'b1, 5'd31);

    applyStimulus(1'b1, 4'd9);
    checkOutput("pre_reset_9", 1'b1, 4'b1101, 4'd9, 1'b0, 5'd31);
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    #1;
    checkOutput("midstream_reset", 1'b0, 4'b0000, 4'd0, 1'b0, 5'd0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b1, 4'd8);
    checkOutput("post_reset_first", 1'b1, 4'b1100, 4'd8, 1'b0, 5'd1);
    applyStimulus(1'b0, 4'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/binary_to_gray_code.md
# binary_to_gray_code

Registered, parameterizable binary-to-Gray encoder with a built-in Gray-to-binary round-trip check and an adjacency monitor. It sits at the boundary where a binary count or address leaves its clock domain or drives a position encoder. Each accepted binary word produces its reflected-binary Gray code one clock later. Status flags confirm that decoding returns the original value and that consecutive outputs differ in exactly one bit.

## Interface
- WIDTH, 4, data width in bits (legal range 2..32)
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  qualifies `binary`; sampled on rising `clk`
- binary  input  WIDTH  unsigned binary value to encode
- gray  output  WIDTH  registered Gray code of the last accepted `binary`
- out_valid  output  1  high for one cycle per accepted input
- binary_back  output  WIDTH  registered Gray-to-binary decode of `gray`'s source value
- roundtrip_err  output  1  high when `binary_back` ≠ the accepted `binary` (sticky until reset)
- single_step  output  1  high with `out_valid` when the new `gray` differs from the previous valid `gray` in exactly one bit
- step_count  output  WIDTH+1  number of accepted inputs since reset, saturating at all-ones

## Operation
- Encode: gray[WIDTH-1] = binary[WIDTH-1]; gray[i] = binary[i+1] ^ binary[i] for i < WIDTH-1. Equivalently, gray = binary ^ (binary >> 1).
- Decode (check path): b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] ^ g[i]. The decode is computed combinationally from the encoded value and registered alongside `gray`.
- On a clock edge with in_valid=1:
  - `gray` and `binary_back` update.
  - out_valid=1.
  - step_count increments, saturating.
  - If `binary_back` ≠ `binary`, roundtrip_err sets.
- On a clock edge with in_valid=0:
  - `gray` and `binary_back` hold.
  - out_valid=0.
  - single_step=0.
- Adjacency monitor:
  - Keep a history register of the last valid `gray` and a flag `have_prev`.
  - single_step = have_prev AND popcount(new_gray ^ prev_gray) == 1.
  - The first valid output after reset gives single_step=0.
  - A repeated identical input gives single_step=0 (Hamming distance 0).
- Wrap-around: binary all-ones → 0 produces gray 100…0 → 000…0, which is one bit, so single_step=1.
- Outputs depend only on accepted inputs. No combinational path from `binary` to any output.

## Timing
- Latency: 1 clock, from in_valid sampled high to out_valid/gray valid. Throughput: one word per clock, and back-to-back in_valid is supported.
- Reset (asynchronous assert, released synchronously to clk by the system):
  - gray=0, binary_back=0, out_valid=0, single_step=0, roundtrip_err=0, step_count=0.
  - have_prev=0, prev_gray=0.
- Reset asserted mid-stream: all outputs go to their reset values immediately (no clock needed). The first valid input after release is treated as "first" (single_step=0).
- single_step and out_valid assert in the same cycle. roundtrip_err asserts in the cycle after the offending input is sampled and never clears without reset.

## Test plan
- Reset: assert reset with in_valid=1 and binary=4'hF, no clock edge → all outputs 0 immediately; they stay 0 while reset is held.
- Full sweep, WIDTH=4: drive binary 0..15 on consecutive cycles.
  - Expect gray 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000.
  - binary_back equals the input each time; roundtrip_err=0; step_count=16.
  - single_step=1 on all outputs except the first.
- Wrap: binary 15 then 0 → gray 1000 then 0000, single_step=1.
- Non-adjacent and repeat:
  - binary 3 then 12 → gray 0010 then 1010, single_step=1.
  - binary 5 then 10 → gray 0111 then 1111, single_step=1.
  - binary 0 then 2 → gray 0000 then 0011, single_step=0.
  - binary 7 twice → single_step=0 on the second output.
- Gaps: in_valid toggling 1,0,1 with binary 4, X, 5 → out_valid 1,0,1; gray holds 0110 during the gap, then becomes 0111; single_step=1 on the third output.
- Mid-stream reset: drive binary 9, pulse reset, then drive binary 8 → after reset, gray=1100 with single_step=0 and step_count=1.
